soc_bus_fabric: RTL
===================

SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 Parameter NSLV, 4, number of slave ports, 1..8 legal.
REQ-002 Parameter SLV_REGION, {4'h0,4'h4,4'he,4'hf}, flattened 4*NSLV-bit vector; slave k owns addresses whose addr[31:28] equals nibble k (nibble 0 is the MSB nibble).
REQ-003 Parameter SLV_WAIT, 16'h0000, flattened 4*NSLV-bit vector; wait states per slave, 0..15.
REQ-004 Parameter SLV_COMB, 4'b0010, NSLV-bit mask; bit k=1 means slave k returns read data combinationally (same cycle), 0 means one cycle after select.
REQ-005 Parameter SLV_SWAP, 4'b0010, NSLV-bit mask; bit k=1 byte-reverses write and read data for slave k.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 m_addr_i  in  32  master address.
REQ-009 m_wdata_i  in  32  master write data.
REQ-010 m_we_i  in  4  master byte write strobes.
REQ-011 m_rdata_o  out  32  read data to master.
REQ-012 m_stall_o  out  1  master stall.
REQ-013 s_sel_o  out  NSLV  one-hot slave select.
REQ-014 s_we_o  out  4*NSLV  per-slave byte write strobes.
REQ-015 s_wdata_o  out  32*NSLV  per-slave write data (swapped per SLV_SWAP).
REQ-016 s_rdata_i  in  32*NSLV  per-slave read data.
REQ-017 err_clr_i  in  1  clears error state (BUS_ERR_EN only).
REQ-018 err_o  out  1  sticky unmapped-write flag (BUS_ERR_EN only).
REQ-019 err_addr_o  out  32  address of first unmapped write (BUS_ERR_EN only).

Function
REQ-020 hit[k] = (m_addr_i[31:28] == SLV_REGION nibble k); on duplicate regions the lowest k wins; s_sel_o = hit, combinational, held during stall.
REQ-021 FSM states IDLE, WAIT; IDLE with hit slave k and W=SLV_WAIT[k]>0 -> WAIT with cnt<=W-1, m_stall_o=1 that cycle.
REQ-022 In WAIT: m_stall_o = (cnt!=0), cnt decrements while nonzero; cnt==0 is the completion cycle (stall low) and the FSM returns to IDLE next edge.
REQ-023 Total stall per access = exactly W cycles; W=0 accesses complete in the presentation cycle with no stall and FSM stays IDLE.
REQ-024 s_we_o for slave k = m_we_i only when hit[k] and m_stall_o==0; otherwise 0, so each write strobes exactly once.
REQ-025 sel_dly (NSLV bits) <= hit on every edge where m_stall_o==0; held while stalled.
REQ-026 m_rdata_o = s_rdata of current hit slave if that slave has SLV_COMB=1; else s_rdata of slave in sel_dly; else 32'h0; swap applied per SLV_SWAP of the chosen slave.
REQ-027 Unmapped address: s_sel_o=0, no stall, no write strobes, m_rdata_o=0 next cycle.
REQ-028 Address change during WAIT is ignored until completion; the FSM uses the slave latched on WAIT entry.

Reset
REQ-029 rst_ni low asynchronously forces: FSM=IDLE, cnt=0, sel_dly=0, m_stall_o=0 (if current slave W=0), err_o=0, err_addr_o=0.
REQ-030 Reset asserted mid-WAIT aborts the access; no write strobe is issued for it.

Configuration
REQ-031 Macro SOC_BUS_ERR_EN defined: write (m_we_i!=0) to unmapped region sets err_o next edge and captures m_addr_i into err_addr_o only if err_o was 0; err_clr_i clears both; simultaneous clear and new error -> error wins.
REQ-032 Macro undefined: err_o and err_addr_o tied to 0, err_clr_i ignored, no error logic synthesised.

Verification
REQ-033 SLV_WAIT slave 1=3, write to 0x4000_0010 we=4'hF -> m_stall_o high 3 cycles, s_we_o[7:4]=4'hF exactly one cycle (4th).
REQ-034 Read 0xE000_0000, slave 2 comb+swap, s_rdata=0x11223344 -> m_rdata_o=0x44332211 same cycle.
REQ-035 Read 0x0000_0100 then 0x4000_0000 back-to-back, slave 0 registered -> cycle 2 m_rdata_o shows slave 0 data.
REQ-036 SOC_BUS_ERR_EN: write 0x8000_0004 then 0x9000_0000 -> err_o=1, err_addr_o=0x8000_0004; err_clr_i pulse -> both 0.
REQ-037 rst_ni low during WAIT cnt=1 -> stall drops immediately, no s_we_o pulse, sel_dly=0.
REQ-038 Duplicate region 4'h4 on slaves 1 and 3, access 0x4000_0000 -> s_sel_o=4'b0010 only.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// Single-master bus fabric: region decode, per-slave wait states, byte swap, comb/registered read mux.
// Optional unmapped-write error capture is built when the SOC_BUS_ERR_EN macro is defined.
module soc_bus_fabric #(
    parameter int                NSLV       = 4,
    parameter logic [4*NSLV-1:0] SLV_REGION = {4'h0, 4'h4, 4'he, 4'hf},
    parameter logic [4*NSLV-1:0] SLV_WAIT   = 16'h0000,
    parameter logic [NSLV-1:0]   SLV_COMB   = 4'b0010,
    parameter logic [NSLV-1:0]   SLV_SWAP   = 4'b0010
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          m_addr_i,
    input  logic [31:0]          m_wdata_i,
    input  logic [3:0]           m_we_i,
    output logic [31:0]          m_rdata_o,
    output logic                 m_stall_o,
    output logic [NSLV-1:0]      s_sel_o,
    output logic [4*NSLV-1:0]    s_we_o,
    output logic [32*NSLV-1:0]   s_wdata_o,
    input  logic [32*NSLV-1:0]   s_rdata_i,
    input  logic                 err_clr_i,
    output logic                 err_o,
    output logic [31:0]          err_addr_o
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    function automatic logic [31:0] swap_if(input logic en, input logic [31:0] d);
        return en ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    // Nibble 0 is the most significant nibble of the flattened vector.
    function automatic logic [3:0] nibble(input logic [4*NSLV-1:0] v, input int k);
        return v[4*(NSLV-1-k) +: 4];
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NSLV-1:0] lat_q, lat_d;
    logic [NSLV-1:0] sel_dly_q, sel_dly_d;
    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] cur_sel;
    logic [3:0]      hit_wait;
    logic            stall;
    logic            comb_hit;
    logic [31:0]     rd_comb;
    logic [31:0]     rd_reg;

    // Descending scan so the lowest-numbered slave wins on duplicate regions.
    always_comb begin
        hit      = '0;
        hit_wait = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (m_addr_i[31:28] == nibble(SLV_REGION, k)) begin
                hit      = '0;
                hit[k]   = 1'b1;
                hit_wait = nibble(SLV_WAIT, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit_wait != 4'd0) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = hit_wait - 4'd1;
                    lat_d   = hit;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // While waiting, the slave latched on entry owns the bus regardless of the address.
    assign cur_sel   = (state_q == ST_WAIT) ? lat_q : hit;
    assign sel_dly_d = stall ? sel_dly_q : cur_sel;
    assign m_stall_o = stall;
    assign s_sel_o   = cur_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            sel_dly_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            sel_dly_q <= sel_dly_d;
        end
    end

    always_comb begin
        s_we_o    = '0;
        s_wdata_o = '0;
        rd_comb   = '0;
        rd_reg    = '0;
        comb_hit  = 1'b0;
        for (int k = 0; k < NSLV; k++) begin
            s_wdata_o[32*k +: 32] = swap_if(SLV_SWAP[k], m_wdata_i);
            if (cur_sel[k] && !stall) begin
                s_we_o[4*k +: 4] = m_we_i;
            end
            if (cur_sel[k] && SLV_COMB[k]) begin
                rd_comb  = rd_comb | swap_if(SLV_SWAP[k], s_rdata_i[32*k +: 32]);
                comb_hit = 1'b1;
            end
            if (sel_dly_q[k]) begin
                rd_reg = rd_reg | swap_if(SLV_SWAP[k], s_rdata_i[32*k +: 32]);
            end
        end
        m_rdata_o = comb_hit ? rd_comb : rd_reg;
    end

`ifdef SOC_BUS_ERR_EN
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        unmapped_wr;

    assign unmapped_wr = (state_q == ST_IDLE) && (hit == '0) && (m_we_i != 4'h0);

    // A clear coinciding with a new error leaves the new error (and its address) captured.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (unmapped_wr) begin
            err_d = 1'b1;
            if (!err_q || err_clr_i) begin
                err_addr_d = m_addr_i;
            end
        end else if (err_clr_i) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
`else
    logic unused_err;
    assign unused_err = ^{err_clr_i, m_addr_i[27:0]};
    assign err_o      = 1'b0;
    assign err_addr_o = '0;
`endif

endmodule
